// File: rtl/writeback_unit_pkg.sv
// Shared widths and the buffered write-entry type for the register-file writeback path.
// Pure declarations: no latency and no backpressure of its own.
package writeback_unit_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_unit_fifo.sv
// wb_fifo: sync FIFO of write entries with per-slot address match; write-to-read 1 cycle.
// Caller must not push when full or pop when empty; reports full/empty only.
module wb_fifo
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  wb_entry_t                        push_entry,
  input  logic                             pop,
  input  logic [REG_ADDR_W-1:0]            q_reg,
  output wb_entry_t                        head_entry,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH)-1:0]         head_ptr,
  output logic [DEPTH-1:0]                 match,
  output logic [DEPTH-1:0][DATA_W-1:0]     ent_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  logic [PTR_W-1:0] offset;
  always_comb begin
    offset   = '0;
    match    = '0;
    ent_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset      = PTR_W'(i) - rd_ptr_q;
      match[i]    = (CNT_W'(offset) < count_q) && (mem_q[i].reg_addr == q_reg);
      ent_data[i] = mem_q[i].data;
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign head_ptr   = rd_ptr_q;
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
endmodule

// File: rtl/writeback_unit.sv
// Two-port writeback arbiter with in-order buffer, output stage and pending-write lookup.
// Accept-to-regWrite 1 + occupancy cycles; both ports stall only when the buffer is full.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aValid,
  input  logic [REG_ADDR_W-1:0] aReg,
  input  logic [DATA_W-1:0]     aData,
  output logic                  aReady,
  input  logic                  bValid,
  input  logic [REG_ADDR_W-1:0] bReg,
  input  logic [DATA_W-1:0]     bData,
  output logic                  bReady,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0]     writeData,
  input  logic [REG_ADDR_W-1:0] qReg,
  output logic                  qPending,
  output logic [DATA_W-1:0]     qData
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic                          space, starve;
  logic                          a_accept, b_accept, acc_vld, enq, bypass;
  logic                          fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_entry_t                     acc_entry, fifo_head;
  logic [PTR_W-1:0]              fifo_head_ptr;
  logic [DEPTH-1:0]              fifo_match;
  logic [DEPTH-1:0][DATA_W-1:0]  fifo_ent_data;

  logic [SC_W-1:0]               starve_cnt_q, starve_cnt_d;
  logic                          reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0]         write_register_q, write_register_d;
  logic [DATA_W-1:0]             write_data_q, write_data_d;

  assign space  = !rst && !fifo_full;
  assign starve = (starve_cnt_q == SC_W'(STARVE_LIMIT));

  // The loser of a contested cycle has its ready masked so the handshake stays exact.
  assign aReady = space && !(bValid && starve);
  assign bReady = space && !(aValid && !starve);

  assign a_accept = aValid && aReady;
  assign b_accept = bValid && bReady;
  assign acc_vld  = a_accept || b_accept;

  always_comb begin
    acc_entry = '0;
    if (b_accept) begin
      acc_entry.reg_addr = bReg;
      acc_entry.data     = bData;
    end else if (a_accept) begin
      acc_entry.reg_addr = aReg;
      acc_entry.data     = aData;
    end
  end

  // Writes to r0 complete their handshake but are dropped here.
  assign enq       = acc_vld && (acc_entry.reg_addr != REG_ZERO);
  assign fifo_pop  = !fifo_empty;
  assign fifo_push = enq && !fifo_empty;
  assign bypass    = enq && fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (acc_entry),
    .pop        (fifo_pop),
    .q_reg      (qReg),
    .head_entry (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_ptr   (fifo_head_ptr),
    .match      (fifo_match),
    .ent_data   (fifo_ent_data)
  );

  always_comb begin
    reg_write_d      = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    if (fifo_pop) begin
      reg_write_d      = 1'b1;
      write_register_d = fifo_head.reg_addr;
      write_data_d     = fifo_head.data;
    end else if (bypass) begin
      reg_write_d      = 1'b1;
      write_register_d = acc_entry.reg_addr;
      write_data_d     = acc_entry.data;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (b_accept || !bValid) begin
      starve_cnt_d = '0;
    end else if (!starve) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q     <= '0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
    end else begin
      starve_cnt_q     <= starve_cnt_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end

  assign regWrite      = reg_write_q;
  assign writeRegister = write_register_q;
  assign writeData     = write_data_q;

  // Walk oldest to youngest so the youngest hit overwrites; the output stage is oldest of all.
  logic [PTR_W-1:0] idx;
  always_comb begin
    qPending = 1'b0;
    qData    = '0;
    idx      = '0;
    if (qReg != REG_ZERO) begin
      if (reg_write_q && (write_register_q == qReg)) begin
        qPending = 1'b1;
        qData    = write_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = fifo_head_ptr + PTR_W'(i);
        if (fifo_match[idx]) begin
          qPending = 1'b1;
          qData    = fifo_ent_data[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Directed and random checks of writeback_unit against a queue-based reference model.
module tb_writeback_unit;
  localparam int DEPTH = 4;
  localparam int LIMIT = 4;

  logic        clk, rst;
  logic        aValid, bValid, aReady, bReady;
  logic [4:0]  aReg, bReg, writeRegister, qReg;
  logic [31:0] aData, bData, writeData, qData;
  logic        regWrite, qPending;

  writeback_unit #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .aValid(aValid), .aReg(aReg), .aData(aData), .aReady(aReady),
    .bValid(bValid), .bReg(bReg), .bData(bData), .bReady(bReady),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .qReg(qReg), .qPending(qPending), .qData(qData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_vld;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          m_starve;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_vld = 1'b0; m_reg = '0; m_data = '0; m_starve = 0;
  endtask

  // Entered at posedge+1; checks mid-cycle, then advances the model across the next edge.
  task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       input logic [4:0] qr);
    logic space, st, e_ar, e_br, e_qp;
    logic [31:0] e_qd;
    int win;
    ent_t e;
    aValid = av; aReg = ar; aData = ad;
    bValid = bv; bReg = br; bData = bd;
    qReg = qr;
    #4;
    space = (mq.size() < DEPTH);
    st    = (m_starve == LIMIT);
    e_ar  = space && !(bv && st);
    e_br  = space && !(av && !st);
    chk("aReady", {31'd0, aReady}, {31'd0, e_ar});
    chk("bReady", {31'd0, bReady}, {31'd0, e_br});
    chk("regWrite", {31'd0, regWrite}, {31'd0, m_vld});
    chk("writeRegister", {27'd0, writeRegister}, {27'd0, m_reg});
    chk("writeData", writeData, m_data);
    e_qp = 1'b0; e_qd = '0;
    if (qr != 0) begin
      if (m_vld && m_reg == qr) begin e_qp = 1'b1; e_qd = m_data; end
      foreach (mq[i]) if (mq[i].r == qr) begin e_qp = 1'b1; e_qd = mq[i].d; end
    end
    chk("qPending", {31'd0, qPending}, {31'd0, e_qp});
    chk("qData", qData, e_qd);
    win = 0;
    if (space) begin
      if (av && bv) win = st ? 2 : 1;
      else if (av)  win = 1;
      else if (bv)  win = 2;
    end
    @(posedge clk);
    if (win == 1 && ar != 0) mq.push_back('{r: ar, d: ad});
    if (win == 2 && br != 0) mq.push_back('{r: br, d: bd});
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_vld = 1'b1; m_reg = e.r; m_data = e.d;
    end else begin
      m_vld = 1'b0;
    end
    if (bv && win != 2) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    else m_starve = 0;
    #1;
  endtask

  task automatic idle(input logic [4:0] qr);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qr);
  endtask

  initial begin
    rst = 1'b1;
    aValid = 0; aReg = 0; aData = 0; bValid = 0; bReg = 0; bData = 0; qReg = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
    chk("rst_writeRegister", {27'd0, writeRegister}, 32'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_aReady", {31'd0, aReady}, 32'd0);
    chk("rst_bReady", {31'd0, bReady}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_aReady", {31'd0, aReady}, 32'd1);

    // Single write with empty buffer: visible one edge later.
    cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5);
    chk("a5_regWrite", {31'd0, regWrite}, 32'd1);
    chk("a5_writeRegister", {27'd0, writeRegister}, 32'd5);
    chk("a5_writeData", writeData, 32'h1234);
    chk("a5_qPending", {31'd0, qPending}, 32'd1);
    chk("a5_qData", qData, 32'h1234);
    idle(5'd5);

    // r0 write: handshake completes, nothing reaches the register file.
    cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd0);
    chk("r0_regWrite", {31'd0, regWrite}, 32'd0);
    chk("r0_qPending", {31'd0, qPending}, 32'd0);
    idle(5'd0);

    // Continuous contention: B gets through every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 5'd1, 32'hA000 + i, 1'b1, 5'd2, 32'hB000 + i, 5'd2);
      chk("starve_bReady_prev", {31'd0, (writeRegister == 5'd2)}, {31'd0, (i % 5 == 4)});
    end
    idle(5'd1);

    // Same-register ordering.
    cycle(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'd0, 5'd7);
    chk("r7_first", writeData, 32'h1);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h2, 5'd7);
    chk("r7_second", writeData, 32'h2);
    chk("r7_qData", qData, 32'h2);
    idle(5'd7);

    // Ten back-to-back writes across pointer wrap, alternating ports.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) cycle(1'b1, 5'(i + 1), 32'hC0 + i, 1'b0, 5'd0, 32'd0, 5'(i + 1));
      else            cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), 32'hC0 + i, 5'(i + 1));
      chk("burst_order", {27'd0, writeRegister}, i + 1);
    end
    idle(5'd3);

    // Asynchronous reset while a write is in the output stage.
    cycle(1'b1, 5'd3, 32'hDEAD, 1'b0, 5'd0, 32'd0, 5'd3);
    chk("pre_rst_regWrite", {31'd0, regWrite}, 32'd1);
    aValid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_regWrite", {31'd0, regWrite}, 32'd0);
    chk("async_rst_aReady", {31'd0, aReady}, 32'd0);
    chk("async_rst_qPending", {31'd0, qPending}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_release_aReady", {31'd0, aReady}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst_release_regWrite", {31'd0, regWrite}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
